// File: rtl/uart_core.sv
// rtl/uart_core.sv - UART transmitter and receiver with configurable framing
// TX and RX run independently; RX samples mid-bit behind a 2-flop synchroniser.
module uart_core #(
  parameter int CLKS_PER_BIT = 234,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       uart_tx,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_parity_err,
  output logic       rx_frame_err,
  output logic       rx_overrun
);

  localparam int            CW    = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]    DLAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]    SLAST = 3'(STOP_BITS - 1);
  localparam logic [7:0]    DMASK = 8'((1 << DATA_BITS) - 1);
  localparam logic          PODD  = (PARITY == 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t        tx_state, tx_next;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;
  logic          tx_par;
  logic          tx_tick;

  assign tx_tick = (tx_cnt == LAST);

  always_comb begin
    tx_next  = tx_state;
    tx_ready = 1'b0;
    uart_tx  = 1'b1;
    case (tx_state)
      S_IDLE: begin
        tx_ready = 1'b1;
        if (tx_valid) tx_next = S_START;
      end
      S_START: begin
        uart_tx = 1'b0;
        if (tx_tick) tx_next = S_DATA;
      end
      S_DATA: begin
        uart_tx = tx_shift[0];
        if (tx_tick && tx_bit == DLAST) tx_next = (PARITY != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        uart_tx = tx_par;
        if (tx_tick) tx_next = S_STOP;
      end
      S_STOP: begin
        if (tx_tick && tx_bit == SLAST) tx_next = S_IDLE;
      end
      default: tx_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
    end else begin
      tx_state <= tx_next;
      if (tx_state == S_IDLE) begin
        tx_cnt <= '0;
        tx_bit <= '0;
        if (tx_valid) begin
          tx_shift <= tx_data & DMASK;
          tx_par   <= ^(tx_data & DMASK) ^ PODD;
        end
      end else if (tx_tick) begin
        // tx_bit counts data bits in DATA and stop bits in STOP
        tx_cnt <= '0;
        tx_bit <= (tx_next != tx_state) ? 3'd0 : tx_bit + 3'd1;
        if (tx_state == S_DATA) tx_shift <= tx_shift >> 1;
      end else begin
        tx_cnt <= tx_cnt + CW'(1);
      end
    end
  end

  logic          rx_meta, rx_sync;
  state_t        rx_state, rx_next;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_pbit;
  logic          rx_sample;
  logic          rx_done;
  logic [7:0]    rx_word;

  always_comb begin
    rx_next   = rx_state;
    rx_sample = 1'b0;
    case (rx_state)
      S_IDLE: begin
        if (!rx_sync) rx_next = S_START;
      end
      S_START: begin
        rx_sample = (rx_cnt == HALF);
        if (rx_sample) rx_next = rx_sync ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        rx_sample = (rx_cnt == LAST);
        if (rx_sample && rx_bit == DLAST) rx_next = (PARITY != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        rx_sample = (rx_cnt == LAST);
        if (rx_sample) rx_next = S_STOP;
      end
      S_STOP: begin
        rx_sample = (rx_cnt == LAST);
        if (rx_sample) rx_next = S_IDLE;
      end
      default: rx_next = S_IDLE;
    endcase
  end

  // Data enters at bit 7, so a short word ends up left-aligned in rx_shift.
  assign rx_word = rx_shift >> (8 - DATA_BITS);
  assign rx_done = (rx_state == S_STOP) && rx_sample;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta       <= 1'b1;
      rx_sync       <= 1'b1;
      rx_state      <= S_IDLE;
      rx_cnt        <= '0;
      rx_bit        <= '0;
      rx_shift      <= '0;
      rx_pbit       <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_meta  <= uart_rx;
      rx_sync  <= rx_meta;
      rx_state <= rx_next;
      if (rx_state == S_IDLE || rx_sample) rx_cnt <= '0;
      else rx_cnt <= rx_cnt + CW'(1);
      if (rx_sample) begin
        rx_bit <= (rx_next != rx_state) ? 3'd0 : rx_bit + 3'd1;
        if (rx_state == S_DATA) rx_shift <= {rx_sync, rx_shift[7:1]};
        if (rx_state == S_PARITY) rx_pbit <= rx_sync;
      end
      rx_overrun <= 1'b0;
      if (rx_done) begin
        rx_data       <= rx_word;
        rx_parity_err <= (PARITY != 0) && (rx_pbit != (^rx_word ^ PODD));
        rx_frame_err  <= !rx_sync;
        rx_valid      <= 1'b1;
        rx_overrun    <= rx_valid && !rx_ready;
      end else if (rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_core.sv
// tb/tb_uart_core.sv - self-checking bench for uart_core
// Instance a: 8E1 driven by bench; instance b: 7N2 looped back onto itself.
module tb_uart_core;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] a_tx_data = 8'h00;
  logic       a_tx_valid = 1'b0;
  logic       a_tx_ready, a_uart_tx;
  logic       a_uart_rx = 1'b1;
  logic [7:0] a_rx_data;
  logic       a_rx_valid;
  logic       a_rx_ready = 1'b0;
  logic       a_perr, a_ferr, a_ovr;

  logic [7:0] b_tx_data = 8'h00;
  logic       b_tx_valid = 1'b0;
  logic       b_tx_ready, b_uart_tx;
  logic [7:0] b_rx_data;
  logic       b_rx_valid;
  logic       b_rx_ready = 1'b0;
  logic       b_perr, b_ferr, b_ovr;

  uart_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst),
    .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready), .uart_tx(a_uart_tx),
    .uart_rx(a_uart_rx), .rx_data(a_rx_data), .rx_valid(a_rx_valid), .rx_ready(a_rx_ready),
    .rx_parity_err(a_perr), .rx_frame_err(a_ferr), .rx_overrun(a_ovr)
  );

  uart_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst),
    .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready), .uart_tx(b_uart_tx),
    .uart_rx(b_uart_tx), .rx_data(b_rx_data), .rx_valid(b_rx_valid), .rx_ready(b_rx_ready),
    .rx_parity_err(b_perr), .rx_frame_err(b_ferr), .rx_overrun(b_ovr)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Line level for each bit slot of a frame; unused trailing slots read as idle/stop 1.
  function automatic logic [15:0] mk_frame(input logic [7:0] d, input int db, input int par);
    logic [15:0] f;
    logic x;
    f = 16'hFFFF;
    f[0] = 1'b0;
    x = 1'b0;
    for (int i = 0; i < db; i++) begin
      f[1 + i] = d[i];
      x = x ^ d[i];
    end
    if (par == 1) f[1 + db] = ~x;
    else if (par == 2) f[1 + db] = x;
    return f;
  endfunction

  typedef struct {
    int         done;
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } rxe_t;

  rxe_t        a_pend[$];
  int          cyc = 0;
  bit          a_busy = 1'b0, b_busy = 1'b0;
  int          a_pos = 0, b_pos = 0;
  logic [15:0] a_frame = 16'hFFFF, b_frame = 16'hFFFF;
  logic        m_valid = 1'b0, m_pe = 1'b0, m_fe = 1'b0, m_ovr = 1'b0;
  logic [7:0]  m_data = 8'h00;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      a_busy  = 1'b0;
      b_busy  = 1'b0;
      m_valid = 1'b0;
      m_data  = 8'h00;
      m_pe    = 1'b0;
      m_fe    = 1'b0;
      m_ovr   = 1'b0;
      a_pend.delete();
    end else begin
      cyc++;
      if (a_busy) begin
        a_pos++;
        if (a_pos == 11 * CPB) a_busy = 1'b0;
      end else if (a_tx_valid) begin
        a_busy  = 1'b1;
        a_pos   = 0;
        a_frame = mk_frame(a_tx_data, 8, 2);
      end
      if (b_busy) begin
        b_pos++;
        if (b_pos == 10 * CPB) b_busy = 1'b0;
      end else if (b_tx_valid) begin
        b_busy  = 1'b1;
        b_pos   = 0;
        b_frame = mk_frame(b_tx_data, 7, 0);
      end
      m_ovr = 1'b0;
      if (a_pend.size() > 0 && a_pend[0].done == cyc) begin
        m_ovr   = m_valid && !a_rx_ready;
        m_valid = 1'b1;
        m_data  = a_pend[0].d;
        m_pe    = a_pend[0].pe;
        m_fe    = a_pend[0].fe;
        void'(a_pend.pop_front());
      end else if (a_rx_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("a_uart_tx", int'(a_uart_tx), int'(a_busy ? a_frame[a_pos / CPB] : 1'b1));
      chk("a_tx_ready", int'(a_tx_ready), int'(!a_busy));
      chk("b_uart_tx", int'(b_uart_tx), int'(b_busy ? b_frame[b_pos / CPB] : 1'b1));
      chk("b_tx_ready", int'(b_tx_ready), int'(!b_busy));
      chk("a_rx_valid", int'(a_rx_valid), int'(m_valid));
      chk("a_rx_data", int'(a_rx_data), int'(m_data));
      chk("a_rx_parity_err", int'(a_perr), int'(m_pe));
      chk("a_rx_frame_err", int'(a_ferr), int'(m_fe));
      chk("a_rx_overrun", int'(a_ovr), int'(m_ovr));
    end
  end

  int ovr_cnt = 0;
  always @(negedge clk) if (!rst && a_ovr) ovr_cnt++;

  // Done edge: two synchroniser edges, half a bit, then ten full bits to the stop sample.
  task automatic send_rx(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    logic [15:0] f;
    rxe_t e;
    f = mk_frame(d, 8, 2);
    if (bad_par) f[9] = ~f[9];
    if (bad_stop) f[10] = 1'b0;
    e.done = cyc + 3 + CPB / 2 + 10 * CPB;
    e.d    = d;
    e.pe   = bad_par;
    e.fe   = bad_stop;
    a_pend.push_back(e);
    for (int i = 0; i < 11; i++) begin
      a_uart_rx = f[i];
      repeat (CPB) @(negedge clk);
    end
    a_uart_rx = 1'b1;
  endtask

  task automatic tx_frame(input bit sel, input logic [7:0] d, input logic [15:0] lv, input int nlev);
    int n;
    n = 0;
    if (sel) begin
      b_tx_data = d;
      b_tx_valid = 1'b1;
    end else begin
      a_tx_data = d;
      a_tx_valid = 1'b1;
    end
    @(negedge clk);
    if (sel) begin
      b_tx_valid = 1'b0;
      b_tx_data = ~d;
    end else begin
      a_tx_valid = 1'b0;
      a_tx_data = ~d;
    end
    while (((sel ? b_tx_ready : a_tx_ready) !== 1'b1) && n < 400) begin
      if (n % CPB == CPB / 2 && n / CPB < nlev)
        chk(sel ? "b_tx_level" : "a_tx_level", int'(sel ? b_uart_tx : a_uart_tx), int'(lv[n / CPB]));
      n++;
      @(negedge clk);
    end
    chk(sel ? "b_tx_busy_cycles" : "a_tx_busy_cycles", n, nlev * CPB);
  endtask

  task automatic consume();
    a_rx_ready = 1'b1;
    @(negedge clk);
    a_rx_ready = 1'b0;
    chk("rx_valid_cleared", int'(a_rx_valid), 0);
  endtask

  initial begin
    int base;
    repeat (3) @(negedge clk);
    chk("rst_a_uart_tx", int'(a_uart_tx), 1);
    chk("rst_a_tx_ready", int'(a_tx_ready), 1);
    chk("rst_a_rx_valid", int'(a_rx_valid), 0);
    chk("rst_a_rx_data", int'(a_rx_data), 0);
    chk("rst_a_flags", int'({a_perr, a_ferr, a_ovr}), 0);
    chk("rst_b_uart_tx", int'(b_uart_tx), 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 0xA5 8E1: 0,1,0,1,0,0,1,0,1,0(parity),1
    tx_frame(1'b0, 8'hA5, 16'h054A, 11);
    repeat (5) @(negedge clk);

    send_rx(8'h3C, 1'b0, 1'b0);
    chk("rx3c_valid", int'(a_rx_valid), 1);
    chk("rx3c_data", int'(a_rx_data), 'h3C);
    chk("rx3c_flags", int'({a_perr, a_ferr}), 0);
    consume();
    repeat (20) @(negedge clk);

    send_rx(8'h3C, 1'b1, 1'b1);
    chk("rxerr_valid", int'(a_rx_valid), 1);
    chk("rxerr_data", int'(a_rx_data), 'h3C);
    chk("rxerr_parity", int'(a_perr), 1);
    chk("rxerr_frame", int'(a_ferr), 1);
    consume();
    repeat (30) @(negedge clk);

    a_uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    a_uart_rx = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_no_valid", int'(a_rx_valid), 0);
    send_rx(8'h55, 1'b0, 1'b0);
    chk("rx55_data", int'(a_rx_data), 'h55);
    chk("rx55_valid", int'(a_rx_valid), 1);
    consume();
    repeat (20) @(negedge clk);

    base = ovr_cnt;
    send_rx(8'h11, 1'b0, 1'b0);
    send_rx(8'h22, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("ovr_pulses", ovr_cnt - base, 1);
    chk("ovr_data", int'(a_rx_data), 'h22);
    chk("ovr_valid", int'(a_rx_valid), 1);
    fork
      send_rx(8'h33, 1'b0, 1'b0);
      begin
        repeat (170) @(negedge clk);
        a_rx_ready = 1'b1;
        @(negedge clk);
        a_rx_ready = 1'b0;
      end
    join
    chk("same_cycle_data", int'(a_rx_data), 'h33);
    chk("same_cycle_valid", int'(a_rx_valid), 1);
    chk("same_cycle_no_ovr", ovr_cnt - base, 1);
    consume();
    repeat (20) @(negedge clk);

    a_tx_data = 8'h0F;
    a_tx_valid = 1'b1;
    fork
      begin
        repeat (100) @(negedge clk);
        a_tx_data = 8'h81;
        repeat (100) @(negedge clk);
        a_tx_valid = 1'b0;
      end
      send_rx(8'hC3, 1'b0, 1'b0);
    join
    repeat (200) @(negedge clk);
    chk("bb_rx_data", int'(a_rx_data), 'hC3);
    chk("bb_tx_idle", int'(a_tx_ready), 1);
    consume();
    repeat (10) @(negedge clk);

    a_tx_data = 8'hA5;
    a_tx_valid = 1'b1;
    @(negedge clk);
    a_tx_valid = 1'b0;
    repeat (4 * CPB + 8) @(negedge clk);
    chk("pre_rst_bit3_low", int'(a_uart_tx), 0);
    #2 rst = 1'b1;
    #1;
    chk("rst_now_uart_tx", int'(a_uart_tx), 1);
    chk("rst_now_tx_ready", int'(a_tx_ready), 1);
    chk("rst_now_rx_valid", int'(a_rx_valid), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tx_frame(1'b0, 8'hFF, 16'h05FE, 11);
    repeat (5) @(negedge clk);

    // 7N2 with bit 7 set on the input: it must not reach the line or rx_data
    tx_frame(1'b1, 8'hFF, 16'h03FE, 10);
    chk("b_rx_valid", int'(b_rx_valid), 1);
    chk("b_rx_data", int'(b_rx_data), 'h7F);
    chk("b_rx_flags", int'({b_perr, b_ferr, b_ovr}), 0);
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
